// File: rtl/alu_rs_if.sv
// alu_rs_if: bundles everything that flows between the ALU reservation
// station, its dispatcher, the two CDBs and the exec unit.
//   master : dispatcher/bus side. Drives stall, flush, dispatch and CDB
//            signals. Observes full and the registered issue bundle.
//   slave  : the reservation station itself.
interface alu_rs_if;
  logic        rdy_in;
  logic        flush_in;
  logic        disp_ok;
  logic [5:0]  disp_opt;
  logic [31:0] disp_vj;
  logic [31:0] disp_vk;
  logic        disp_qj_rdy;
  logic        disp_qk_rdy;
  logic [3:0]  disp_qj;
  logic [3:0]  disp_qk;
  logic [31:0] disp_imm;
  logic [3:0]  disp_en;
  logic        CDB_1_ok;
  logic [3:0]  CDB_1_en;
  logic [31:0] CDB_1_val;
  logic        CDB_2_ok;
  logic [3:0]  CDB_2_en;
  logic [31:0] CDB_2_val;
  logic        full;
  logic        rs_ok;
  logic [5:0]  opt;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] imm;
  logic [3:0]  en;

  modport master (
    output rdy_in, flush_in, disp_ok, disp_opt, disp_vj, disp_vk,
           disp_qj_rdy, disp_qk_rdy, disp_qj, disp_qk, disp_imm, disp_en,
           CDB_1_ok, CDB_1_en, CDB_1_val, CDB_2_ok, CDB_2_en, CDB_2_val,
    input  full, rs_ok, opt, rs1, rs2, imm, en
  );

  modport slave (
    input  rdy_in, flush_in, disp_ok, disp_opt, disp_vj, disp_vk,
           disp_qj_rdy, disp_qk_rdy, disp_qj, disp_qk, disp_imm, disp_en,
           CDB_1_ok, CDB_1_en, CDB_1_val, CDB_2_ok, CDB_2_en, CDB_2_val,
    output full, rs_ok, opt, rs1, rs2, imm, en
  );
endinterface

// File: rtl/alu_rs.sv
// alu_rs: reservation station for the integer ALU.
// Buffers dispatched micro-ops. Captures operands from CDB_1 (ALU) and
// CDB_2 (load/store), at dispatch time and afterwards. Issues the
// lowest-index ready entry each cycle through a registered bundle.
// Ports:
//   clk_in : clock, rising edge.
//   rst_in : asynchronous active-low reset.
//   bus    : alu_rs_if.slave. Carries stall, flush, dispatch, both CDBs,
//            full, and the issue bundle (rs_ok/opt/rs1/rs2/imm/en).
module alu_rs #(
  parameter int RS_SIZE = 8
) (
  input  logic    clk_in,
  input  logic    rst_in,
  alu_rs_if.slave bus
);

  // Returns {ready, value}. A ready operand keeps its value. Otherwise
  // CDB_1 wins over CDB_2 when both carry the matching tag.
  function automatic logic [32:0] capture(
    input logic        rdy,
    input logic [31:0] v,
    input logic [3:0]  q,
    input logic        c1_ok,
    input logic [3:0]  c1_en,
    input logic [31:0] c1_val,
    input logic        c2_ok,
    input logic [3:0]  c2_en,
    input logic [31:0] c2_val
  );
    if (rdy)                        return {1'b1, v};
    else if (c1_ok && c1_en == q)   return {1'b1, c1_val};
    else if (c2_ok && c2_en == q)   return {1'b1, c2_val};
    else                            return {1'b0, v};
  endfunction

  // Entry state
  logic [RS_SIZE-1:0] busy_reg;
  logic [5:0]         opt_reg    [RS_SIZE];
  logic [31:0]        vj_reg     [RS_SIZE];
  logic [31:0]        vk_reg     [RS_SIZE];
  logic [3:0]         qj_reg     [RS_SIZE];
  logic [3:0]         qk_reg     [RS_SIZE];
  logic               qj_rdy_reg [RS_SIZE];
  logic               qk_rdy_reg [RS_SIZE];
  logic [31:0]        imm_reg    [RS_SIZE];
  logic [3:0]         en_reg     [RS_SIZE];

  // Issue bundle
  logic        rs_ok_reg;
  logic [5:0]  opt_out_reg;
  logic [31:0] rs1_reg;
  logic [31:0] rs2_reg;
  logic [31:0] imm_out_reg;
  logic [3:0]  en_out_reg;

  logic [RS_SIZE-1:0] elig;
  logic [RS_SIZE-1:0] disp_sel;
  logic [RS_SIZE-1:0] issue_sel;
  logic [32:0]        wake_j [RS_SIZE];
  logic [32:0]        wake_k [RS_SIZE];
  logic [32:0]        disp_j;
  logic [32:0]        disp_k;
  logic               full;
  logic               do_disp;
  logic               do_issue;
  logic [5:0]         iss_opt;
  logic [31:0]        iss_vj;
  logic [31:0]        iss_vk;
  logic [31:0]        iss_imm;
  logic [3:0]         iss_en;

  assign full     = &busy_reg;
  assign do_disp  = bus.disp_ok & ~full & bus.rdy_in & ~bus.flush_in;
  assign do_issue = bus.rdy_in & (|elig);

  // One-hot lowest free slot and lowest eligible slot. x & -x isolates the
  // lowest set bit. For the free slot, this is applied to ~busy.
  assign disp_sel  = ~busy_reg & (busy_reg + RS_SIZE'(1));
  assign issue_sel = elig & (~elig + RS_SIZE'(1));

  assign disp_j = capture(bus.disp_qj_rdy, bus.disp_vj, bus.disp_qj,
                          bus.CDB_1_ok, bus.CDB_1_en, bus.CDB_1_val,
                          bus.CDB_2_ok, bus.CDB_2_en, bus.CDB_2_val);
  assign disp_k = capture(bus.disp_qk_rdy, bus.disp_vk, bus.disp_qk,
                          bus.CDB_1_ok, bus.CDB_1_en, bus.CDB_1_val,
                          bus.CDB_2_ok, bus.CDB_2_en, bus.CDB_2_val);

  for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
    assign elig[gi]   = busy_reg[gi] & qj_rdy_reg[gi] & qk_rdy_reg[gi];
    assign wake_j[gi] = capture(qj_rdy_reg[gi], vj_reg[gi], qj_reg[gi],
                                bus.CDB_1_ok, bus.CDB_1_en, bus.CDB_1_val,
                                bus.CDB_2_ok, bus.CDB_2_en, bus.CDB_2_val);
    assign wake_k[gi] = capture(qk_rdy_reg[gi], vk_reg[gi], qk_reg[gi],
                                bus.CDB_1_ok, bus.CDB_1_en, bus.CDB_1_val,
                                bus.CDB_2_ok, bus.CDB_2_en, bus.CDB_2_val);
  end

  // issue_sel is one-hot or zero, so an OR-mux is enough.
  always_comb begin
    iss_opt = '0;
    iss_vj  = '0;
    iss_vk  = '0;
    iss_imm = '0;
    iss_en  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (issue_sel[i]) begin
        iss_opt = iss_opt | opt_reg[i];
        iss_vj  = iss_vj  | vj_reg[i];
        iss_vk  = iss_vk  | vk_reg[i];
        iss_imm = iss_imm | imm_reg[i];
        iss_en  = iss_en  | en_reg[i];
      end
    end
  end

  // Control state: busy bits and the issue bundle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_reg    <= '0;
      rs_ok_reg   <= 1'b0;
      opt_out_reg <= '0;
      rs1_reg     <= '0;
      rs2_reg     <= '0;
      imm_out_reg <= '0;
      en_out_reg  <= '0;
    end else if (bus.flush_in) begin
      busy_reg  <= '0;
      rs_ok_reg <= 1'b0;
    end else begin
      // The issued slot is busy and the dispatch slot is free, so the
      // two masks never overlap.
      busy_reg  <= (busy_reg & ~(do_issue ? issue_sel : '0))
                 | (do_disp ? disp_sel : '0);
      rs_ok_reg <= do_issue;
      if (do_issue) begin
        opt_out_reg <= iss_opt;
        rs1_reg     <= iss_vj;
        rs2_reg     <= iss_vk;
        imm_out_reg <= iss_imm;
        en_out_reg  <= iss_en;
      end
    end
  end

  // Payload needs no reset; busy gates every use of it. Wakeup keeps
  // running through stalls.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < RS_SIZE; i++) begin
      if (do_disp && disp_sel[i]) begin
        opt_reg[i] <= bus.disp_opt;
        qj_reg[i]  <= bus.disp_qj;
        qk_reg[i]  <= bus.disp_qk;
        imm_reg[i] <= bus.disp_imm;
        en_reg[i]  <= bus.disp_en;
        {qj_rdy_reg[i], vj_reg[i]} <= disp_j;
        {qk_rdy_reg[i], vk_reg[i]} <= disp_k;
      end else if (busy_reg[i]) begin
        {qj_rdy_reg[i], vj_reg[i]} <= wake_j[i];
        {qk_rdy_reg[i], vk_reg[i]} <= wake_k[i];
      end
    end
  end

  assign bus.full  = full;
  assign bus.rs_ok = rs_ok_reg;
  assign bus.opt   = opt_out_reg;
  assign bus.rs1   = rs1_reg;
  assign bus.rs2   = rs2_reg;
  assign bus.imm   = imm_out_reg;
  assign bus.en    = en_out_reg;

endmodule

// File: tb/tb_alu_rs.sv
module tb_alu_rs;
  localparam logic [5:0] OPT_ADD  = 6'd1;
  localparam logic [5:0] OPT_ADDI = 6'd2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  alu_rs_if bus();

  alu_rs #(.RS_SIZE(8)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rdy_in      = 1'b1;
    bus.flush_in    = 1'b0;
    bus.disp_ok     = 1'b0;
    bus.disp_opt    = '0;
    bus.disp_vj     = '0;
    bus.disp_vk     = '0;
    bus.disp_qj_rdy = 1'b0;
    bus.disp_qk_rdy = 1'b0;
    bus.disp_qj     = '0;
    bus.disp_qk     = '0;
    bus.disp_imm    = '0;
    bus.disp_en     = '0;
    bus.CDB_1_ok    = 1'b0;
    bus.CDB_1_en    = '0;
    bus.CDB_1_val   = '0;
    bus.CDB_2_ok    = 1'b0;
    bus.CDB_2_en    = '0;
    bus.CDB_2_val   = '0;
  endtask

  task automatic disp(input logic [5:0] o, input logic [31:0] vj, input logic jr,
                      input logic [3:0] qj, input logic [31:0] vk, input logic kr,
                      input logic [3:0] qk, input logic [31:0] im, input logic [3:0] e);
    bus.disp_ok     = 1'b1;
    bus.disp_opt    = o;
    bus.disp_vj     = vj;
    bus.disp_qj_rdy = jr;
    bus.disp_qj     = qj;
    bus.disp_vk     = vk;
    bus.disp_qk_rdy = kr;
    bus.disp_qk     = qk;
    bus.disp_imm    = im;
    bus.disp_en     = e;
    $display("dispatch opt=%0d en=%0d qj_rdy=%0b qk_rdy=%0b", o, e, jr, kr);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();

    // Reset held with a dispatch pending: nothing may be captured.
    rst_n = 1'b0;
    disp(OPT_ADDI, 32'd9, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd1, 4'd9);
    repeat (3) tick();
    check("reset_full", bus.full, 1'b0);
    check("reset_rs_ok", bus.rs_ok, 1'b0);
    check("reset_en", bus.en, 4'd0);
    check("reset_rs1", bus.rs1, 32'd0);
    idle();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_reset_no_issue", bus.rs_ok, 1'b0);

    // Ready dispatch: issue one edge after capture.
    disp(OPT_ADDI, 32'd5, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd7, 4'd3);
    tick();
    idle();
    check("ready_not_yet", bus.rs_ok, 1'b0);
    tick();
    check("ready_rs_ok", bus.rs_ok, 1'b1);
    check("ready_rs1", bus.rs1, 32'd5);
    check("ready_imm", bus.imm, 32'd7);
    check("ready_en", bus.en, 4'd3);
    check("ready_opt", bus.opt, OPT_ADDI);
    tick();
    check("ready_one_cycle", bus.rs_ok, 1'b0);
    check("ready_en_hold", bus.en, 4'd3);

    // Wakeup via CDB_2.
    disp(OPT_ADD, 32'd0, 1'b0, 4'd4, 32'd1, 1'b1, 4'd0, 32'd0, 4'd5);
    tick();
    idle();
    tick();
    check("wake_waiting", bus.rs_ok, 1'b0);
    bus.CDB_2_ok = 1'b1; bus.CDB_2_en = 4'd4; bus.CDB_2_val = 32'd10;
    tick();
    idle();
    check("wake_no_bypass", bus.rs_ok, 1'b0);
    tick();
    check("wake_rs_ok", bus.rs_ok, 1'b1);
    check("wake_rs1", bus.rs1, 32'd10);
    check("wake_rs2", bus.rs2, 32'd1);
    check("wake_en", bus.en, 4'd5);
    tick();

    // Dispatch-time forwarding with CDB_1 priority.
    disp(OPT_ADD, 32'd0, 1'b0, 4'd6, 32'd3, 1'b1, 4'd0, 32'd0, 4'd7);
    bus.CDB_1_ok = 1'b1; bus.CDB_1_en = 4'd6; bus.CDB_1_val = 32'd11;
    bus.CDB_2_ok = 1'b1; bus.CDB_2_en = 4'd6; bus.CDB_2_val = 32'd22;
    tick();
    idle();
    tick();
    check("fwd_rs_ok", bus.rs_ok, 1'b1);
    check("fwd_rs1_cdb1", bus.rs1, 32'd11);
    check("fwd_rs2", bus.rs2, 32'd3);
    tick();

    // Fill all 8 entries, waiting on tag 2, then try a 9th that is ready.
    for (int i = 0; i < 8; i++) begin
      check("fill_not_full", bus.full, 1'b0);
      disp(OPT_ADD, 32'd0, 1'b0, 4'd2, 32'd100 + 32'(i), 1'b1, 4'd0, 32'd0, 4'(i));
      tick();
    end
    check("fill_full", bus.full, 1'b1);
    disp(OPT_ADDI, 32'd999, 1'b1, 4'd0, 32'd999, 1'b1, 4'd0, 32'd0, 4'd15);
    tick();
    idle();
    check("ninth_no_issue", bus.rs_ok, 1'b0);
    check("ninth_full", bus.full, 1'b1);
    bus.CDB_1_ok = 1'b1; bus.CDB_1_en = 4'd2; bus.CDB_1_val = 32'd42;
    tick();
    idle();
    check("fill_wake_no_bypass", bus.rs_ok, 1'b0);
    check("fill_still_full", bus.full, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      $display("issue slot %0d: rs_ok=%0b en=%0d rs2=%0d", i, bus.rs_ok, bus.en, bus.rs2);
      check("order_rs_ok", bus.rs_ok, 1'b1);
      check("order_en", bus.en, 32'(i));
      check("order_rs1", bus.rs1, 32'd42);
      check("order_rs2", bus.rs2, 32'd100 + 32'(i));
      check("order_full", bus.full, 1'b0);
    end
    tick();
    check("ninth_discarded", bus.rs_ok, 1'b0);

    // Stall: three entries woken during rdy_in=0 must not issue.
    for (int i = 0; i < 3; i++) begin
      disp(OPT_ADD, 32'd0, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'd0, 4'd10 + 4'(i));
      tick();
    end
    idle();
    bus.rdy_in = 1'b0;
    bus.CDB_1_ok = 1'b1; bus.CDB_1_en = 4'd9; bus.CDB_1_val = 32'd77;
    tick();
    bus.CDB_1_ok = 1'b0;
    check("stall_no_issue1", bus.rs_ok, 1'b0);
    tick();
    check("stall_no_issue2", bus.rs_ok, 1'b0);
    check("stall_en_hold", bus.en, 4'd7);
    // Flush together with a dispatch: flush wins.
    bus.rdy_in = 1'b1;
    disp(OPT_ADDI, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd0, 4'd13);
    bus.flush_in = 1'b1;
    tick();
    idle();
    check("flush_rs_ok", bus.rs_ok, 1'b0);
    check("flush_full", bus.full, 1'b0);
    tick();
    check("flush_empty1", bus.rs_ok, 1'b0);
    tick();
    check("flush_empty2", bus.rs_ok, 1'b0);
    disp(OPT_ADDI, 32'd8, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0, 4'd14);
    tick();
    idle();
    tick();
    check("after_flush_rs_ok", bus.rs_ok, 1'b1);
    check("after_flush_en", bus.en, 4'd14);
    tick();

    // Asynchronous reset mid-operation while full.
    for (int i = 0; i < 8; i++) begin
      disp(OPT_ADD, 32'd0, 1'b0, 4'd12, 32'd0, 1'b1, 4'd0, 32'd0, 4'(i));
      tick();
    end
    idle();
    check("areset_pre_full", bus.full, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_full_now", bus.full, 1'b0);
    check("areset_en_now", bus.en, 4'd0);
    tick();
    rst_n = 1'b1;
    bus.CDB_1_ok = 1'b1; bus.CDB_1_en = 4'd12; bus.CDB_1_val = 32'd5;
    tick();
    idle();
    tick();
    check("areset_discarded", bus.rs_ok, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station for the integer ALU. It buffers dispatched ALU and branch-compare micro-ops and captures operand values broadcast on the two CDBs. Each cycle it issues at most one ready entry to the combinational `exec` unit through a registered output bundle. It sits between the dispatcher (upstream) and `exec` (downstream); `exec` drives CDB_1, which feeds back into this block.

## Interface
- RS_SIZE, 8, number of entries; power of two, 2..16.
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  global ready; low = stall.
- flush_in  input  1  misprediction flush.
- disp_ok  input  1  dispatch valid.
- disp_opt  input  6  opcode in `def.v` encoding.
- disp_vj, disp_vk  input  32  operand values, meaningful when the matching ready bit is 1.
- disp_qj_rdy, disp_qk_rdy  input  1  operand already available.
- disp_qj, disp_qk  input  4  ROB tag of the producer when not ready.
- disp_imm  input  32  immediate.
- disp_en  input  4  destination ROB tag.
- CDB_1_ok, CDB_2_ok  input  1  broadcast valid (CDB_1 = ALU, CDB_2 = load/store).
- CDB_1_en, CDB_2_en  input  4  broadcast ROB tag.
- CDB_1_val, CDB_2_val  input  32  broadcast value.
- full  output  1  all entries busy; combinational from registered state.
- rs_ok  output  1  issue bundle valid (registered).
- opt  output  6  issued opcode (registered).
- rs1, rs2  output  32  issued operand values (registered).
- imm  output  32  issued immediate (registered).
- en  output  4  issued destination tag (registered).

## Operation
- Per entry: busy, opt, vj, qj, qj_rdy, vk, qk, qk_rdy, imm, en.
- **Dispatch.**
  - When disp_ok=1, full=0, rdy_in=1 and flush_in=0, the bundle is written into the lowest-index non-busy entry and busy is set.
  - When disp_ok=1 and full=1, the dispatch is ignored and no entry changes. The dispatcher must not do this.
- **Dispatch-time forwarding.** For each operand with ready bit 0:
  - If CDB_1_ok and CDB_1_en equals its tag, store CDB_1_val and set ready.
  - Otherwise, if CDB_2_ok and CDB_2_en equals its tag, store CDB_2_val and set ready.
- **Wakeup.**
  - Each edge, every busy entry applies the same match to each non-ready operand.
  - CDB_1 has priority if both buses carry the same tag.
  - Wakeup continues while rdy_in=0.
- **Select.**
  - Eligible means busy, qj_rdy=1 and qk_rdy=1, evaluated on registered state.
  - The lowest-index eligible entry is chosen.
  - At the edge, the outputs load opt, vj→rs1, vk→rs2, imm and en, rs_ok is set to 1, and the entry's busy is cleared.
  - If no entry is eligible, rs_ok is set to 0 and the other outputs hold their values.
- Operands captured by dispatch or wakeup at edge t are issuable no earlier than edge t+1. There is no same-edge bypass into the outputs.
- An entry freed at edge t can be refilled by a dispatch at edge t+1. full does not anticipate a same-edge issue.
- **rdy_in=0.** No dispatch capture and no issue. rs_ok goes to 0 at the edge; the other outputs hold.
- **Flush.**
  - flush_in=1 at an edge clears every busy bit and sets rs_ok to 0.
  - Flush overrides a simultaneous dispatch, wakeup or issue.
  - Entry payloads need not be cleared.
- **Reset.**
  - rst_in low forces all busy bits, rs_ok, opt, rs1, rs2, imm and en to 0 immediately.
  - As a result, full=0.
  - Reset mid-operation discards all entries.

## Timing
- Dispatch with both operands ready at edge t: rs_ok=1 in the cycle after edge t+1, and the `exec` result is on CDB_1 in that same cycle.
- Operand woken by a CDB at edge t: issue at edge t+1 at the earliest.
- Throughput is one issue per cycle. rs_ok holds for exactly one cycle per issued entry.
- full changes only on clock edges or on reset assertion.

## Test plan
- **Reset.**
  - Stimulus: hold rst_in low for 3 cycles with disp_ok=1.
  - Response: full=0, rs_ok=0, en=0; after release no entry is busy.
- **Ready dispatch.**
  - Stimulus: dispatch ADDI at edge 1 with vj=5, qj_rdy=1, imm=7, en=3.
  - Response: rs_ok=1 after edge 2 with rs1=5, imm=7, en=3; rs_ok=0 after edge 3.
- **Wakeup.**
  - Stimulus: dispatch ADD with qj=4 (not ready) and vk=1 ready; at edge 3 present CDB_2_ok=1, en=4, val=10.
  - Response: issue at edge 4 with rs1=10, rs2=1.
- **Forwarding at dispatch, with priority.**
  - Stimulus: dispatch at the same edge where CDB_1 and CDB_2 both carry tag 6, with values 11 and 22 respectively.
  - Response: vj=11 is captured and the entry issues at the next edge.
- **Fill and ordering.**
  - Stimulus: dispatch 8 entries with qj=2 not ready, then a 9th.
  - Response: full=1 and the 9th dispatch is ignored. CDB tag 2 wakes all 8, which issue in index order 0..7 on 8 consecutive cycles, and full drops after the first issue.
- **Flush and stall.**
  - Stimulus: 3 ready entries, rdy_in=0 for 2 cycles, then flush_in=1 together with disp_ok=1.
  - Response: no issue during the stall; after the flush, full=0, rs_ok=0 and no entry is busy.
